// File: rtl/blink_tk_reverse_stack_if.sv
// Tweakey push/replay bus between the key schedule, the reverse stack
// and the inverse-round loop. slave = the stack, master = its neighbours.
interface blink_tk_reverse_stack_if #(
    parameter int WIDTH = 128,
    parameter int NR    = 32,
    parameter int IDXW  = $clog2(NR)
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_tk;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_tk;
    logic [IDXW-1:0]  out_round;
    logic             out_last;

    modport slave (
        input  in_valid, in_tk, out_ready,
        output in_ready, out_valid, out_tk, out_round, out_last
    );

    modport master (
        output in_valid, in_tk, out_ready,
        input  in_ready, out_valid, out_tk, out_round, out_last
    );
endinterface

// File: rtl/blink_tk_reverse_stack.sv
// Reverse-order round-tweakey buffer for Blink-128 decryption.
// Fills NR keys in forward order, then replays them last-first on each
// start pulse; the stored set survives replays until clear or reset.
module blink_tk_reverse_stack #(
    parameter int WIDTH = 128,
    parameter int NR    = 32,
    parameter int IDXW  = $clog2(NR)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic start,
    output logic loaded,
    output logic busy,
    blink_tk_reverse_stack_if.slave bus
);
    typedef enum logic [1:0] {FILL, LOADED, DRAIN} state_t;

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NR - 1);

    state_t           state;
    logic [IDXW-1:0]  wr_cnt;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_tk_q;
    logic [IDXW-1:0]  out_round_q;
    logic [WIDTH-1:0] mem [NR];

    // in_ready is high exactly in FILL, so it doubles as the push qualifier
    logic push;
    assign push = bus.in_valid && in_ready_q;

    // Key storage: write-only from FILL; no reset, contents are rewritten on refill
    always_ff @(posedge clk) begin
        if (rst_n && !clear && push)
            mem[wr_cnt] <= bus.in_tk;
    end

    // Control FSM with registered outputs; clear overrides every other event
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= FILL;
            wr_cnt      <= '0;
            in_ready_q  <= 1'b1;
            loaded      <= 1'b0;
            busy        <= 1'b0;
            out_valid_q <= 1'b0;
            out_tk_q    <= '0;
            out_round_q <= '0;
        end else if (clear) begin
            // out_tk/out_round deliberately hold; they are don't-care while invalid
            state       <= FILL;
            wr_cnt      <= '0;
            in_ready_q  <= 1'b1;
            loaded      <= 1'b0;
            busy        <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (push) begin
                        wr_cnt <= wr_cnt + IDXW'(1);
                        if (wr_cnt == LAST_IDX) begin
                            state      <= LOADED;
                            in_ready_q <= 1'b0;
                            loaded     <= 1'b1;
                        end
                    end
                end
                LOADED: begin
                    if (start) begin
                        state       <= DRAIN;
                        loaded      <= 1'b0;
                        busy        <= 1'b1;
                        out_valid_q <= 1'b1;
                        out_tk_q    <= mem[LAST_IDX];
                        out_round_q <= LAST_IDX;
                    end
                end
                DRAIN: begin
                    // start is ignored here, including on the final handshake
                    if (bus.out_ready) begin
                        if (out_round_q == '0) begin
                            state       <= LOADED;
                            loaded      <= 1'b1;
                            busy        <= 1'b0;
                            out_valid_q <= 1'b0;
                        end else begin
                            out_tk_q    <= mem[out_round_q - IDXW'(1)];
                            out_round_q <= out_round_q - IDXW'(1);
                        end
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_tk    = out_tk_q;
    assign bus.out_round = out_round_q;
    assign bus.out_last  = out_valid_q && (out_round_q == '0);
endmodule

// File: tb/tb_blink_tk_reverse_stack.sv
// Directed bench: NR=4 instance for build/replay/backpressure/clear,
// default NR=32 instance for mid-fill reset and a full-depth replay.
module tb_blink_tk_reverse_stack;
    logic clk;
    logic rst4, clear4, start4, loaded4, busy4;
    logic rst32, clear32, start32, loaded32, busy32;
    int   nchk  = 0;
    int   nfail = 0;

    blink_tk_reverse_stack_if #(.WIDTH(128), .NR(4))  b4 ();
    blink_tk_reverse_stack_if #(.WIDTH(128), .NR(32)) b32 ();

    blink_tk_reverse_stack #(.WIDTH(128), .NR(4)) d4 (
        .clk(clk), .rst_n(rst4), .clear(clear4), .start(start4),
        .loaded(loaded4), .busy(busy4), .bus(b4.slave)
    );

    blink_tk_reverse_stack d32 (
        .clk(clk), .rst_n(rst32), .clear(clear32), .start(start32),
        .loaded(loaded32), .busy(busy32), .bus(b32.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        nchk++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] key4(input logic [31:0] base, input int i);
        logic [31:0] w;
        w = base + 32'(i);
        return {w, w, w, w};
    endfunction

    function automatic logic [127:0] key32(input int i);
        logic [31:0] w;
        w = 32'(i);
        return {32'hA5A5_0000 | w, ~w, w * 32'd3, 32'h0BAD_0000 + w};
    endfunction

    task automatic fill4(input logic [31:0] base);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("fill4_ready%0d", i), 128'(b4.in_ready), 128'd1);
            b4.in_valid = 1'b1;
            b4.in_tk    = key4(base, i);
            tick();
        end
        b4.in_valid = 1'b0;
        chk("fill4_ready_drop", 128'(b4.in_ready), 128'd0);
        chk("fill4_loaded", 128'(loaded4), 128'd1);
        chk("fill4_busy", 128'(busy4), 128'd0);
        chk("fill4_ovalid", 128'(b4.out_valid), 128'd0);
    endtask

    // mode 0: out_ready always 1; mode 1: out_ready pattern 1,0,0,1,0,0,...
    task automatic replay4(input string nm, input int mode, input logic [31:0] base,
                           input bit start_at_end);
        int k = 3;
        int c = 0;
        logic rdy;
        b4.out_ready = 1'b0;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        while (k >= 0 && c < 40) begin
            chk($sformatf("%s_valid_c%0d", nm, c), 128'(b4.out_valid), 128'd1);
            chk($sformatf("%s_busy_c%0d", nm, c), 128'(busy4), 128'd1);
            chk($sformatf("%s_tk_c%0d", nm, c), b4.out_tk, key4(base, k));
            chk($sformatf("%s_round_c%0d", nm, c), 128'(b4.out_round), 128'(k));
            chk($sformatf("%s_last_c%0d", nm, c), 128'(b4.out_last), 128'(k == 0));
            rdy = (mode == 0) ? 1'b1 : (c % 3 == 0);
            b4.out_ready = rdy;
            if (start_at_end && k == 0 && rdy) start4 = 1'b1;
            tick();
            start4 = 1'b0;
            if (rdy) k--;
            c++;
        end
        if (k >= 0) chk({nm, "_timeout"}, 128'd0, 128'd1);
        b4.out_ready = 1'b0;
        chk({nm, "_end_valid"}, 128'(b4.out_valid), 128'd0);
        chk({nm, "_end_loaded"}, 128'(loaded4), 128'd1);
        chk({nm, "_end_busy"}, 128'(busy4), 128'd0);
    endtask

    initial begin
        rst4 = 1'b0; clear4 = 1'b0; start4 = 1'b0;
        rst32 = 1'b0; clear32 = 1'b0; start32 = 1'b0;
        b4.in_valid = 1'b0; b4.in_tk = '0; b4.out_ready = 1'b0;
        b32.in_valid = 1'b0; b32.in_tk = '0; b32.out_ready = 1'b0;
        tick();
        tick();

        // reset values
        chk("rst_in_ready", 128'(b4.in_ready), 128'd1);
        chk("rst_loaded", 128'(loaded4), 128'd0);
        chk("rst_busy", 128'(busy4), 128'd0);
        chk("rst_ovalid", 128'(b4.out_valid), 128'd0);
        chk("rst_olast", 128'(b4.out_last), 128'd0);
        chk("rst_otk", b4.out_tk, 128'd0);
        chk("rst_oround", 128'(b4.out_round), 128'd0);
        rst4 = 1'b1;
        rst32 = 1'b1;

        // start in FILL is ignored
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        chk("fill_start_ignored", 128'(b4.out_valid), 128'd0);

        fill4(32'h1000_0000);
        // in_valid in LOADED is ignored
        b4.in_valid = 1'b1;
        b4.in_tk = '1;
        tick();
        b4.in_valid = 1'b0;
        chk("loaded_push_ignored", 128'(b4.in_ready), 128'd0);

        replay4("rep", 0, 32'h1000_0000, 1'b0);
        replay4("bp", 1, 32'h1000_0000, 1'b0);
        replay4("rep2", 0, 32'h1000_0000, 1'b1);
        chk("endstart_ignored_valid", 128'(b4.out_valid), 128'd0);
        replay4("rep3", 0, 32'h1000_0000, 1'b0);

        // clear mid-replay after tk3 and tk2 are consumed
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        b4.out_ready = 1'b1;
        tick();
        tick();
        chk("clr_pre_tk", b4.out_tk, key4(32'h1000_0000, 1));
        clear4 = 1'b1;
        tick();
        clear4 = 1'b0;
        b4.out_ready = 1'b0;
        chk("clr_ovalid", 128'(b4.out_valid), 128'd0);
        chk("clr_in_ready", 128'(b4.in_ready), 128'd1);
        chk("clr_busy", 128'(busy4), 128'd0);
        chk("clr_loaded", 128'(loaded4), 128'd0);
        fill4(32'h2000_0000);
        replay4("new", 0, 32'h2000_0000, 1'b0);

        // NR=32: reset mid-fill after two pushes
        for (int i = 0; i < 2; i++) begin
            b32.in_valid = 1'b1;
            b32.in_tk = 128'hDEAD;
            tick();
        end
        b32.in_valid = 1'b0;
        rst32 = 1'b0;
        tick();
        chk("r32_in_ready", 128'(b32.in_ready), 128'd1);
        chk("r32_loaded", 128'(loaded32), 128'd0);
        chk("r32_busy", 128'(busy32), 128'd0);
        chk("r32_ovalid", 128'(b32.out_valid), 128'd0);
        chk("r32_olast", 128'(b32.out_last), 128'd0);
        chk("r32_otk", b32.out_tk, 128'd0);
        chk("r32_oround", 128'(b32.out_round), 128'd0);
        rst32 = 1'b1;

        for (int i = 0; i < 32; i++) begin
            chk($sformatf("f32_ready%0d", i), 128'(b32.in_ready), 128'd1);
            b32.in_valid = 1'b1;
            b32.in_tk = key32(i);
            tick();
        end
        b32.in_valid = 1'b0;
        chk("f32_ready_drop", 128'(b32.in_ready), 128'd0);
        chk("f32_loaded", 128'(loaded32), 128'd1);

        start32 = 1'b1;
        tick();
        start32 = 1'b0;
        b32.out_ready = 1'b1;
        for (int k = 31; k >= 0; k--) begin
            chk($sformatf("r32_valid%0d", k), 128'(b32.out_valid), 128'd1);
            chk($sformatf("r32_tk%0d", k), b32.out_tk, key32(k));
            chk($sformatf("r32_round%0d", k), 128'(b32.out_round), 128'(k));
            chk($sformatf("r32_last%0d", k), 128'(b32.out_last), 128'(k == 0));
            tick();
        end
        b32.out_ready = 1'b0;
        chk("r32_end_valid", 128'(b32.out_valid), 128'd0);
        chk("r32_end_loaded", 128'(loaded32), 128'd1);

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end
endmodule
